// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind the multicycle datapath's shared memory port,
// with programmable wait states, byte/word accesses and illegal-access flagging.
// Optional build macro MEM_STATS_EN adds read/write/error counters as extra outputs.
`timescale 1ns/1ps
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_acc,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] ADR_LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic access_illegal(input logic [31:0] a, input logic rd,
                                            input logic wr, input logic bacc);
        return ({1'b0, a} >= ADR_LIMIT) || (!bacc && (a[1:0] != 2'b00)) || (rd && wr);
    endfunction

    function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [7:0] b,
                                             input logic [1:0] lane);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [3:0]      wait_cnt_r;
    logic [AW+1:0]   adr_r;
    logic [31:0]     wdata_r;
    logic            byte_r;
    logic            rd_r;
    logic            wr_r;
    logic            illegal_r;
    logic [31:0]     read_data_r;
    logic            ready_r;
    logic            busy_r;
    logic            error_r;
    logic [31:0]     mem_r [DEPTH];

    logic            req_s;
    logic            accept_s;
    logic            illegal_in_s;
    logic [AW+1:0]   cur_adr_s;
    logic            cur_rd_s;
    logic            cur_byte_s;
    logic            cur_illegal_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     rd_data_next_s;
    logic            resp_next_s;
    logic            busy_next_s;
    logic            rd_load_s;
    logic            mem_we_s;
    logic [31:0]     wr_word_s;

    assign req_s        = mem_read | mem_write;
    assign accept_s     = (state_r == ST_IDLE) && req_s;
    assign illegal_in_s = access_illegal(adr, mem_read, mem_write, byte_acc);

    // With zero wait states the response is formed on the accepting edge, so use live inputs in IDLE.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_adr_s     = adr[AW+1:0];
            cur_rd_s      = mem_read;
            cur_byte_s    = byte_acc;
            cur_illegal_s = illegal_in_s;
        end else begin
            cur_adr_s     = adr_r;
            cur_rd_s      = rd_r;
            cur_byte_s    = byte_r;
            cur_illegal_s = illegal_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (WS == 4'd0) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r >= WS) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the coming edge.
    always_comb begin
        resp_next_s = (next_state_s == ST_RESP);
        busy_next_s = (next_state_s != ST_IDLE);
        rd_load_s   = resp_next_s && cur_rd_s;
        mem_we_s    = (state_r == ST_RESP) && wr_r && !illegal_r;
        rd_word_s   = mem_r[cur_adr_s[AW+1:2]];
        if (cur_illegal_s) begin
            rd_data_next_s = 32'd0;
        end else if (cur_byte_s) begin
            rd_data_next_s = {24'd0, lane_get(rd_word_s, cur_adr_s[1:0])};
        end else begin
            rd_data_next_s = rd_word_s;
        end
        if (byte_r) begin
            wr_word_s = lane_put(mem_r[adr_r[AW+1:2]], wdata_r[7:0], adr_r[1:0]);
        end else begin
            wr_word_s = wdata_r;
        end
    end

    // Wait-state counter, starts at 1 on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            wait_cnt_r <= 4'd1;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Request capture at acceptance; inputs are ignored until the response completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_r     <= '0;
            wdata_r   <= 32'd0;
            byte_r    <= 1'b0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            adr_r     <= adr[AW+1:0];
            wdata_r   <= write_data;
            byte_r    <= byte_acc;
            rd_r      <= mem_read;
            wr_r      <= mem_write;
            illegal_r <= illegal_in_s;
        end
    end

    // Registered handshake outputs and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_r <= 32'd0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            ready_r <= resp_next_s;
            busy_r  <= busy_next_s;
            error_r <= resp_next_s && cur_illegal_s;
            if (rd_load_s) begin
                read_data_r <= rd_data_next_s;
            end
        end
    end

    // RAM write on the closing edge of RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[adr_r[AW+1:2]] <= wr_word_s;
        end
    end

    assign read_data = read_data_r;
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign error     = error_r;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_r;
    logic [31:0] wr_count_r;
    logic [15:0] err_count_r;

    // Access statistics, counted on the RESP cycle; the error count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_r  <= 32'd0;
            wr_count_r  <= 32'd0;
            err_count_r <= 16'd0;
        end else if (state_r == ST_RESP) begin
            if (illegal_r) begin
                if (err_count_r != 16'hFFFF) begin
                    err_count_r <= err_count_r + 16'd1;
                end
            end else if (rd_r) begin
                rd_count_r <= rd_count_r + 32'd1;
            end else if (wr_r) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign rd_count  = rd_count_r;
    assign wr_count  = wr_count_r;
    assign err_count = err_count_r;
`endif

endmodule
